cache_miss_ctrl: RTL and testbench
==================================

// Module: cache_miss_ctrl
// PURPOSE
//  Sequencing FSM for one 4-way set-associative cache. Accepts CPU requests and
//  sequences tag lookup, LRU update, dirty-victim writeback and line refill.
//  Drives LRU_replace (hit_en/index), the tag/data array strobes and the memory
//  burst interface. Sits between the CPU load/store port and the cache arrays.
// PARAMETERS
//  WAY_NUM      4   ways per set; hit_way, victim_way and lru_hit_en are one-hot
//  INDEX_WIDTH  4   set index bits (16 lines)
//  OFFSET_WIDTH 4   byte offset bits; line = 2^OFFSET_WIDTH bytes
//  ADDR_WIDTH   32  byte address width; TAG = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH
//  BURST_LEN    4   32-bit words per line = 2^(OFFSET_WIDTH-2)
// PORTS
//  clk           in   1            clock, rising edge
//  rst           in   1            asynchronous reset, active-high
//  cpu_req       in   1            CPU request valid
//  cpu_we        in   1            1 = store, 0 = load
//  cpu_addr      in   ADDR_WIDTH   request byte address
//  cpu_ready     out  1            controller can accept a request (IDLE)
//  cpu_resp      out  1            one-cycle completion pulse
//  hit_way       in   WAY_NUM      tag-compare result for latched index
//  dirty_way     in   WAY_NUM      dirty bits of latched set
//  victim_way    in   WAY_NUM      LRU_replace wayN_replace_en, packed {3..0}
//  victim_tag    in   TAG          stored tag of the selected victim
//  lru_hit_en    out  WAY_NUM      to LRU_replace hit_en; 0 = NO_HIT
//  lru_index     out  INDEX_WIDTH  to LRU_replace index / array address
//  tag_we        out  1            write tag/valid/dirty of fill_way
//  fill_way      out  WAY_NUM      one-hot way for tag_we/data_we/wb_rd
//  data_we       out  1            write refill word to data array
//  word_sel      out  log2(BURST_LEN) word index for data_we/wb_rd
//  wb_rd         out  1            read victim word for writeback
//  mem_req/mem_we out 1/1          memory request; 1 = writeback burst
//  mem_addr      out  ADDR_WIDTH   line base address (offset bits zero)
//  mem_ready     in   1            accepts request (refill) / one beat (writeback)
//  mem_rvalid    in   1            one refill beat returned
// BEHAVIOUR
//  Reset: state IDLE, beat=0; all outputs 0 except cpu_ready=1. Reset mid-burst
//   abandons the transfer; no further mem_req is issued.
//  Hit latency 2 cycles (accept->LOOKUP->RESP). States and transitions:
//  IDLE:   cpu_ready=1; on cpu_req latch addr/we -> LOOKUP.
//  LOOKUP: lru_index=latched index. |hit_way: lru_hit_en=hit_way for 1 cycle
//          -> RESP. Miss: lru_hit_en=0; latch victim_way as fill_way;
//          (dirty_way & victim_way)!=0 -> WB, else -> REFILL.
//  WB:     mem_req=mem_we=1, mem_addr={victim_tag,index,0}; wb_rd=1,
//          word_sel=beat. beat++ on each mem_ready; on last beat (BURST_LEN-1),
//          beat=0 -> REFILL.
//  REFILL: mem_req=1 (mem_we=0), mem_addr={tag,index,0}, held until mem_ready,
//          then deasserted. Each mem_rvalid: data_we=1, word_sel=beat, beat++.
//          On last beat -> UPDATE.
//  UPDATE: tag_we=1 (valid=1, dirty=cpu_we), lru_hit_en=fill_way 1 cycle -> RESP.
//  RESP:   cpu_resp=1 one cycle -> IDLE. cpu_req ignored outside IDLE.
//  Beat counter wraps to 0 after BURST_LEN-1. mem_rvalid outside REFILL ignored.
//  Multi-hot hit_way/victim_way: lowest index wins; victim_way==0: way0.
//  lru_hit_en is non-zero only in LOOKUP-hit and UPDATE cycles.
// TESTING
//  1 Hit: index 3, hit_way=0100 -> lru_hit_en=0100 1 cycle, cpu_resp 2 cycles
//    after accept, no mem_req.
//  2 Clean miss: hit_way=0, victim_way=0010, dirty_way=0 -> REFILL only;
//    4 data_we, word_sel 0..3; tag_we + lru_hit_en=0010; cpu_resp.
//  3 Dirty miss: victim_way=1000, dirty_way=1000, victim_tag=0x1234 ->
//    4 WB beats at {0x1234,idx,0}, then refill, UPDATE, cpu_resp.
//  4 mem_ready stalled 5 cycles in WB/REFILL -> beat holds, mem_req stays 1.
//  5 rst pulse during REFILL beat 2 -> IDLE, cpu_ready=1, mem_req=0;
//    next request restarts at beat 0.
//  6 Back-to-back hits, indices 0..15 -> lru_index tracks each request;
//    one lru_hit_en pulse per request.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Miss/hit sequencer for a 4-way set-associative cache: tag lookup, LRU touch,
// dirty-victim writeback burst and line refill burst.
module cache_miss_ctrl #(
   parameter  int WAY_NUM      = 4,
   parameter  int INDEX_WIDTH  = 4,
   parameter  int OFFSET_WIDTH = 4,
   parameter  int ADDR_WIDTH   = 32,
   localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
   localparam int BURST_LEN    = 2 ** (OFFSET_WIDTH - 2),
   localparam int WORD_WIDTH   = $clog2(BURST_LEN)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cpu_req_i,
   input  logic                   cpu_we_i,
   input  logic [ADDR_WIDTH-1:0]  cpu_addr_i,
   output logic                   cpu_ready_o,
   output logic                   cpu_resp_o,
   input  logic [WAY_NUM-1:0]     hit_way_i,
   input  logic [WAY_NUM-1:0]     dirty_way_i,
   input  logic [WAY_NUM-1:0]     victim_way_i,
   input  logic [TAG_WIDTH-1:0]   victim_tag_i,
   output logic [WAY_NUM-1:0]     lru_hit_en_o,
   output logic [INDEX_WIDTH-1:0] lru_index_o,
   output logic                   tag_we_o,
   output logic                   tag_dirty_o,
   output logic [WAY_NUM-1:0]     fill_way_o,
   output logic                   data_we_o,
   output logic [WORD_WIDTH-1:0]  word_sel_o,
   output logic                   wb_rd_o,
   output logic                   mem_req_o,
   output logic                   mem_we_o,
   output logic [ADDR_WIDTH-1:0]  mem_addr_o,
   input  logic                   mem_ready_i,
   input  logic                   mem_rvalid_i
);

   // state  | meaning
   // IDLE   | ready for a CPU request
   // LOOKUP | tag compare result valid for latched index
   // WB     | writing dirty victim line back, one beat per mem_ready
   // REFILL | refill request issued, collecting mem_rvalid beats
   // UPDATE | write tag/valid/dirty, touch LRU with the filled way
   // RESP   | one-cycle completion pulse to the CPU
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      WB     = 3'd2,
      REFILL = 3'd3,
      UPDATE = 3'd4,
      RESP   = 3'd5
   } state_t;

   localparam logic [WORD_WIDTH-1:0] BEAT_LAST = WORD_WIDTH'(BURST_LEN - 1);
   localparam logic [WORD_WIDTH-1:0] BEAT_ONE  = WORD_WIDTH'(1);
   localparam logic [WAY_NUM-1:0]    WAY0      = WAY_NUM'(1);

   state_t                 state_q, state_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;
   logic                   we_q, we_d;
   logic [WAY_NUM-1:0]     fill_way_q, fill_way_d;
   logic [TAG_WIDTH-1:0]   vtag_q, vtag_d;
   logic [WORD_WIDTH-1:0]  beat_q, beat_d;
   logic                   req_done_q, req_done_d;

   logic [WAY_NUM-1:0]     hit_sel;
   logic [WAY_NUM-1:0]     vic_sel;
   logic                   unused_offset;

   // Multi-hot inputs resolve to the lowest-numbered way.
   function automatic logic [WAY_NUM-1:0] lowest_one(input logic [WAY_NUM-1:0] v);
      logic [WAY_NUM-1:0] r;
      r = '0;
      for (int i = WAY_NUM - 1; i >= 0; i--) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   assign unused_offset = ^cpu_addr_i[OFFSET_WIDTH-1:0];
   assign hit_sel       = lowest_one(hit_way_i);
   assign vic_sel       = (victim_way_i == '0) ? WAY0 : lowest_one(victim_way_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tag_q      <= '0;
         index_q    <= '0;
         we_q       <= 1'b0;
         fill_way_q <= '0;
         vtag_q     <= '0;
         beat_q     <= '0;
         req_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         index_q    <= index_d;
         we_q       <= we_d;
         fill_way_q <= fill_way_d;
         vtag_q     <= vtag_d;
         beat_q     <= beat_d;
         req_done_q <= req_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      index_d      = index_q;
      we_d         = we_q;
      fill_way_d   = fill_way_q;
      vtag_d       = vtag_q;
      beat_d       = beat_q;
      req_done_d   = req_done_q;

      cpu_ready_o  = 1'b0;
      cpu_resp_o   = 1'b0;
      lru_hit_en_o = '0;
      lru_index_o  = index_q;
      tag_we_o     = 1'b0;
      tag_dirty_o  = 1'b0;
      fill_way_o   = '0;
      data_we_o    = 1'b0;
      word_sel_o   = '0;
      wb_rd_o      = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;

      case (state_q)
         IDLE: begin
            cpu_ready_o = 1'b1;
            if (cpu_req_i) begin
               tag_d   = cpu_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
               index_d = cpu_addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
               we_d    = cpu_we_i;
               state_d = LOOKUP;
            end
         end

         LOOKUP: begin
            if (|hit_way_i) begin
               lru_hit_en_o = hit_sel;
               state_d      = RESP;
            end else begin
               fill_way_d = vic_sel;
               vtag_d     = victim_tag_i;
               beat_d     = '0;
               req_done_d = 1'b0;
               state_d    = (|(dirty_way_i & vic_sel)) ? WB : REFILL;
            end
         end

         WB: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = {vtag_q, index_q, {OFFSET_WIDTH{1'b0}}};
            wb_rd_o    = 1'b1;
            word_sel_o = beat_q;
            fill_way_o = fill_way_q;
            if (mem_ready_i) begin
               if (beat_q == BEAT_LAST) begin
                  beat_d     = '0;
                  req_done_d = 1'b0;
                  state_d    = REFILL;
               end else begin
                  beat_d = beat_q + BEAT_ONE;
               end
            end
         end

         REFILL: begin
            // The request is held only until the memory accepts it once.
            mem_req_o  = ~req_done_q;
            mem_addr_o = req_done_q ? '0 : {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
            word_sel_o = beat_q;
            fill_way_o = fill_way_q;
            if (mem_ready_i && !req_done_q) begin
               req_done_d = 1'b1;
            end
            if (mem_rvalid_i) begin
               data_we_o = 1'b1;
               if (beat_q == BEAT_LAST) begin
                  beat_d  = '0;
                  state_d = UPDATE;
               end else begin
                  beat_d = beat_q + BEAT_ONE;
               end
            end
         end

         UPDATE: begin
            tag_we_o     = 1'b1;
            tag_dirty_o  = we_q;
            fill_way_o   = fill_way_q;
            lru_hit_en_o = fill_way_q;
            state_d      = RESP;
         end

         RESP: begin
            cpu_resp_o = 1'b1;
            state_d    = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares them as the controller produces them.
module tb_cache_miss_ctrl;

   localparam int K_LRU = 1;
   localparam int K_WB  = 2;
   localparam int K_RFQ = 3;
   localparam int K_DAT = 4;
   localparam int K_TAG = 5;
   localparam int K_RSP = 6;
   localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk, rst;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr;
   logic        cpu_ready, cpu_resp;
   logic [3:0]  hit_way, dirty_way, victim_way;
   logic [23:0] victim_tag;
   logic [3:0]  lru_hit_en;
   logic [3:0]  lru_index;
   logic        tag_we, tag_dirty;
   logic [3:0]  fill_way;
   logic        data_we;
   logic [1:0]  word_sel;
   logic        wb_rd, mem_req, mem_we;
   logic [31:0] mem_addr;
   logic        mem_ready, mem_rvalid;

   cache_miss_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cpu_req_i    (cpu_req),
      .cpu_we_i     (cpu_we),
      .cpu_addr_i   (cpu_addr),
      .cpu_ready_o  (cpu_ready),
      .cpu_resp_o   (cpu_resp),
      .hit_way_i    (hit_way),
      .dirty_way_i  (dirty_way),
      .victim_way_i (victim_way),
      .victim_tag_i (victim_tag),
      .lru_hit_en_o (lru_hit_en),
      .lru_index_o  (lru_index),
      .tag_we_o     (tag_we),
      .tag_dirty_o  (tag_dirty),
      .fill_way_o   (fill_way),
      .data_we_o    (data_we),
      .word_sel_o   (word_sel),
      .wb_rd_o      (wb_rd),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_ready_i  (mem_ready),
      .mem_rvalid_i (mem_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [63:0] val;
      logic [63:0] mask;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   mem_req_cycles = 0;
   int   since_acc = 0;

   task automatic push(input int k, input logic [63:0] v, input logic [63:0] m);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.mask = m;
      expq.push_back(e);
   endtask

   task automatic record(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic observe(input int k, input logic [63:0] v);
      exp_t e;
      n_checks++;
      if (expq.size() == 0) begin
         $display("FAIL unexpected_event: got kind %0d val %h expected no event", k, v);
      end else begin
         e = expq.pop_front();
         if (e.kind == k && ((v ^ e.val) & e.mask) == 64'd0) n_pass++;
         else $display("FAIL event_kind%0d: got kind %0d val %h expected kind %0d val %h",
                       e.kind, k, v, e.kind, e.val);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         since_acc++;
         if (mem_req) mem_req_cycles++;
         if (lru_hit_en != 4'd0)           observe(K_LRU, {lru_index, lru_hit_en});
         if (mem_req && mem_we && mem_ready)  observe(K_WB, {mem_addr, wb_rd, word_sel});
         if (mem_req && !mem_we && mem_ready) observe(K_RFQ, {32'd0, mem_addr});
         if (data_we)                      observe(K_DAT, {fill_way, word_sel});
         if (tag_we)                       observe(K_TAG, {fill_way, tag_dirty});
         if (cpu_resp)                     observe(K_RSP, 64'(since_acc));
         if (cpu_ready && cpu_req) since_acc = 0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready;
      int n;
      n = 0;
      while (!cpu_ready && n < 50) begin
         tick;
         n++;
      end
      if (!cpu_ready) record("ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_hit(input logic [3:0] idx, input logic [3:0] hway,
                         input logic [3:0] exp_lru, input logic we);
      int base;
      wait_ready;
      base     = mem_req_cycles;
      hit_way  = hway;
      cpu_addr = {24'hABC000 | {20'd0, idx}, idx, 4'h8};
      cpu_we   = we;
      cpu_req  = 1'b1;
      push(K_LRU, {60'd0, idx, exp_lru}, ALL);
      push(K_RSP, 64'd2, ALL);
      tick;
      cpu_req = 1'b0;
      tick;
      tick;
      hit_way = 4'd0;
      record("hit_no_mem_req", 64'(mem_req_cycles - base), 64'd0);
   endtask

   task automatic do_miss(input logic [3:0] idx, input logic [23:0] tag, input logic we,
                          input logic [3:0] vway, input logic [3:0] dway,
                          input logic [23:0] vtag, input logic [3:0] exp_fill,
                          input logic exp_wb, input int wb_stall, input int rf_stall,
                          input int abort_after);
      int nb;
      int base;
      nb = (abort_after != 0) ? abort_after : 4;
      wait_ready;
      hit_way    = 4'd0;
      victim_way = vway;
      dirty_way  = dway;
      victim_tag = vtag;
      cpu_addr   = {tag, idx, 4'h4};
      cpu_we     = we;
      cpu_req    = 1'b1;
      if (exp_wb)
         for (int b = 0; b < 4; b++) push(K_WB, {29'd0, vtag, idx, 4'h0, 1'b1, 2'(b)}, ALL);
      push(K_RFQ, {32'd0, tag, idx, 4'h0}, ALL);
      for (int b = 0; b < nb; b++) push(K_DAT, {58'd0, exp_fill, 2'(b)}, ALL);
      if (abort_after == 0) begin
         push(K_LRU, {56'd0, idx, exp_fill}, ALL);
         push(K_TAG, {59'd0, exp_fill, we}, ALL);
         push(K_RSP, 64'd0, 64'd0);
      end
      tick;
      cpu_req = 1'b0;
      tick;
      if (exp_wb) begin
         for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
               for (int s = 0; s < wb_stall; s++) begin
                  mem_rvalid = 1'b1;
                  tick;
                  record("wb_stall_hold", {60'd0, mem_req, mem_we, word_sel}, {60'd0, 2'b11, 2'(b)});
               end
               mem_rvalid = 1'b0;
            end
            mem_ready = 1'b1;
            tick;
            mem_ready = 1'b0;
         end
      end
      for (int s = 0; s < rf_stall; s++) begin
         cpu_req = 1'b1;
         tick;
         record("refill_stall_req", {62'd0, mem_req, mem_we}, {62'd0, 2'b10});
      end
      cpu_req   = 1'b0;
      mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      record("refill_req_dropped", {63'd0, mem_req}, 64'd0);
      for (int b = 0; b < nb; b++) begin
         mem_rvalid = 1'b1;
         tick;
         mem_rvalid = 1'b0;
         if (b < nb - 1) tick;
      end
      if (abort_after != 0) begin
         rst = 1'b1;
         #2;
         record("abort_ready", {63'd0, cpu_ready}, 64'd1);
         record("abort_mem_req", {63'd0, mem_req}, 64'd0);
         record("abort_strobes", {58'd0, data_we, tag_we, lru_hit_en}, 64'd0);
         @(posedge clk);
         #1;
         rst  = 1'b0;
         base = mem_req_cycles;
         repeat (4) tick;
         record("abort_no_mem_req", 64'(mem_req_cycles - base), 64'd0);
      end else begin
         tick;
         tick;
      end
      victim_way = 4'd0;
      dirty_way  = 4'd0;
      victim_tag = 24'd0;
   endtask

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0;
      hit_way = 4'd0; dirty_way = 4'd0; victim_way = 4'd0; victim_tag = 24'd0;
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      record("reset_ready_resp", {62'd0, cpu_ready, cpu_resp}, 64'd2);
      record("reset_lru", {56'd0, lru_hit_en, lru_index}, 64'd0);
      record("reset_mem", {30'd0, mem_req, mem_we, mem_addr}, 64'd0);
      record("reset_strobes", {55'd0, tag_we, data_we, wb_rd, fill_way, word_sel}, 64'd0);
      rst = 1'b0;
      tick;

      do_hit(4'd3, 4'b0100, 4'b0100, 1'b0);
      do_hit(4'd5, 4'b0110, 4'b0010, 1'b1);
      do_miss(4'd7, 24'h00A5A5, 1'b0, 4'b0010, 4'b0000, 24'h0,      4'b0010, 1'b0, 0, 0, 0);
      do_miss(4'd9, 24'h000077, 1'b1, 4'b1000, 4'b1000, 24'h001234, 4'b1000, 1'b1, 0, 0, 0);
      do_miss(4'd2, 24'hC0FFEE, 1'b1, 4'b0100, 4'b0100, 24'hBEEF01, 4'b0100, 1'b1, 5, 5, 0);
      do_miss(4'd4, 24'h111111, 1'b0, 4'b1010, 4'b1000, 24'h222222, 4'b0010, 1'b0, 0, 1, 0);
      do_miss(4'd6, 24'h333333, 1'b0, 4'b0000, 4'b0001, 24'h444444, 4'b0001, 1'b1, 0, 0, 0);
      do_miss(4'd11, 24'h555555, 1'b0, 4'b0001, 4'b0000, 24'h0,     4'b0001, 1'b0, 0, 2, 2);
      do_miss(4'd11, 24'h555556, 1'b1, 4'b0100, 4'b0000, 24'h0,     4'b0100, 1'b0, 0, 0, 0);
      for (int i = 0; i < 16; i++)
         do_hit(4'(i), 4'(1 << (i % 4)), 4'(1 << (i % 4)), 1'b0);

      repeat (10) tick;
      record("scoreboard_drained", 64'(expq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

endmodule
